// File: rtl/rf_multiport.sv
// Multi-port register file: two write ports, NUM_RD bypassed read ports,
// and a per-register busy scoreboard for hazard detection.
module rf_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned SP_IDX   = 29,
  parameter logic [31:0] SP_RESET = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [AW-1:0]            wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [AW-1:0]            wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   w_sp_rst;

  assign w_sp_rst = DATA_W'(SP_RESET);

  // Port 1 is written last so it wins an address collision with port 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == SP_IDX) ? w_sp_rst : '0;
      end
    end else begin
      if (we0 && (wa0 != '0)) r_regs[wa0] <= wd0;
      if (we1 && (wa1 != '0)) r_regs[wa1] <= wd1;
    end
  end

  // Issue is applied after the write clears: the issuing instruction is the newer producer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      if (we0) r_busy[wa0] <= 1'b0;
      if (we1) r_busy[wa1] <= 1'b0;
      if (iss_valid && (iss_addr != '0)) r_busy[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0] w_ra;
    rd    = '0;
    rbusy = '0;
    w_ra  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      w_ra = ra[i*AW +: AW];
      if (w_ra == '0) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rbusy[i]               = 1'b0;
      end else if (we1 && (wa1 == w_ra)) begin
        rd[i*DATA_W +: DATA_W] = wd1;
        rbusy[i]               = 1'b0;
      end else if (we0 && (wa0 == w_ra)) begin
        rd[i*DATA_W +: DATA_W] = wd0;
        rbusy[i]               = 1'b0;
      end else begin
        rd[i*DATA_W +: DATA_W] = r_regs[w_ra];
        rbusy[i]               = r_busy[w_ra];
      end
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (default 32x32, two read ports).
module tb_rf_multiport;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic           clk;
  logic           reset;
  logic           we0, we1, iss_valid;
  logic [AW-1:0]  wa0, wa1, iss_addr;
  logic [DW-1:0]  wd0, wd1;
  logic [AW-1:0]  ra0, ra1;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]  rbusy;

  int n_pass  = 0;
  int n_total = 0;

  rf_multiport #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .SP_IDX(29), .SP_RESET(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra({ra1, ra0}), .rd(rd), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
  endtask

  initial begin
    idle();
    reset = 1'b0; ra0 = 5'd29; ra1 = 5'd5;
    #12;
    chk("rst_sp",    rd[31:0],  32'hFFFF_FFFF);
    chk("rst_r5",    rd[63:32], 32'h0);
    chk("rst_busy",  {30'd0, rbusy}, 32'h0);

    // Release and write addr 3 with same-cycle bypass
    reset = 1'b1;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD_BEEF; ra0 = 5'd3;
    #1;
    chk("byp_w0",    rd[31:0], 32'hDEAD_BEEF);
    chk("byp_w0_bz", {31'd0, rbusy[0]}, 32'h0);
    tick(); idle(); #1;
    chk("store_w0",  rd[31:0], 32'hDEAD_BEEF);

    // Collision on addr 7: port 1 wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222_2222;
    ra0 = 5'd7; ra1 = 5'd3;
    #1;
    chk("coll_byp",  rd[31:0],  32'h2222_2222);
    chk("other_r3",  rd[63:32], 32'hDEAD_BEEF);
    tick(); idle(); #1;
    chk("coll_st",   rd[31:0],  32'h2222_2222);

    // Distinct addresses written together
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_000A;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0000_000B;
    ra0 = 5'd10; ra1 = 5'd11;
    #1;
    chk("dual_byp0", rd[31:0],  32'h0000_000A);
    chk("dual_byp1", rd[63:32], 32'h0000_000B);
    tick(); idle(); #1;
    chk("dual_st0",  rd[31:0],  32'h0000_000A);
    chk("dual_st1",  rd[63:32], 32'h0000_000B);

    // Register 0 ignores writes and issues
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h0000_1234;
    iss_valid = 1'b1; iss_addr = 5'd0; ra0 = 5'd0;
    #1;
    chk("r0_byp",    rd[31:0], 32'h0);
    chk("r0_byp_bz", {31'd0, rbusy[0]}, 32'h0);
    tick(); idle(); #1;
    chk("r0_st",     rd[31:0], 32'h0);
    chk("r0_bz",     {31'd0, rbusy[0]}, 32'h0);

    // Scoreboard on addr 9
    iss_valid = 1'b1; iss_addr = 5'd9; ra0 = 5'd9;
    #1;
    chk("iss_same",  {31'd0, rbusy[0]}, 32'h0);
    tick(); idle(); #1;
    chk("iss_next",  {31'd0, rbusy[0]}, 32'h1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0099;
    iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    chk("wi_bz",     {31'd0, rbusy[0]}, 32'h0);
    chk("wi_byp",    rd[31:0], 32'h0000_0099);
    tick(); idle(); #1;
    chk("wi_next",   {31'd0, rbusy[0]}, 32'h1);
    chk("wi_st",     rd[31:0], 32'h0000_0099);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0077;
    #1;
    chk("wr_bz",     {31'd0, rbusy[0]}, 32'h0);
    tick(); idle(); #1;
    chk("wr_clr",    {31'd0, rbusy[0]}, 32'h0);
    chk("wr_st",     rd[31:0], 32'h0000_0077);

    // Mid-operation asynchronous reset
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hAAAA_AAAA;
    tick(); idle();
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick(); idle();
    ra0 = 5'd4; ra1 = 5'd29;
    #1;
    chk("pre_rst_d", rd[31:0], 32'hAAAA_AAAA);
    chk("pre_rst_b", {31'd0, rbusy[0]}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_d", rd[31:0],  32'h0);
    chk("mid_rst_b", {30'd0, rbusy}, 32'h0);
    chk("mid_rst_sp", rd[63:32], 32'hFFFF_FFFF);
    tick();
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
